// File: rtl/capture_sweep.sv
// capture_sweep: steps the signal_centre channel selector across every antenna
// input, waits for each channel to lock, records the locked phases and reduces
// them to one common capture phase using circular (mod RATIO) arithmetic.
module capture_sweep #(
    parameter int WIDTH  = 24,
    parameter int SBITS  = 5,
    parameter int RATIO  = 12,
    parameter int RBITS  = 4,
    parameter int FLUSH  = 4,
    parameter int SETTLE = 4,
    parameter int TBITS  = 12
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [SBITS-1:0] select_o,
    output logic             align_o,
    output logic             cstart_o,
    output logic             creset_o,
    output logic             restart_o,
    input  logic             strobe_i,
    input  logic             locked_i,
    input  logic             invalid_i,
    input  logic [RBITS-1:0] phase_i,
    output logic [RBITS-1:0] phase_o,
    output logic [RBITS-1:0] spread_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] fail_o
);

    localparam int FCW = (FLUSH > 1) ? $clog2(FLUSH) : 1;
    localparam int STW = $clog2(SETTLE + 1);

    localparam logic [RBITS:0]   RATIO_W   = (RBITS+1)'(RATIO);
    localparam logic [RBITS:0]   HALF_W    = (RBITS+1)'(RATIO / 2);
    localparam logic [RBITS:0]   BACK_W    = (RBITS+1)'(RATIO - RATIO / 2);
    localparam logic [TBITS-1:0] TMO_LAST  = {TBITS{1'b1}} - TBITS'(1);
    localparam logic [SBITS-1:0] SEL_LAST  = SBITS'(WIDTH - 1);
    localparam logic [FCW-1:0]   FLUSH_END = FCW'(FLUSH - 1);
    localparam logic [STW-1:0]   SETTLE_M1 = STW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_ALIGN,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [SBITS-1:0] sel_q, sel_d;
    logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [STW-1:0]   settle_q, settle_d;
    logic [TBITS-1:0] tmo_q, tmo_d;
    logic [RBITS-1:0] min_q, min_d, max_q, max_d;
    logic [RBITS-1:0] minr_q, minr_d, maxr_q, maxr_d;
    logic             any_q, any_d;
    logic [WIDTH-1:0] fail_work_q, fail_work_d;

    logic             busy_q, busy_d, done_q, done_d;
    logic             align_q, align_d, cstart_q, cstart_d;
    logic             creset_q, creset_d, restart_q, restart_d;
    logic [RBITS-1:0] phase_q, phase_d, spread_q, spread_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] fail_q, fail_d;

    // Rotated copy of the incoming phase: r = (p + H) mod RATIO.
    logic [RBITS:0]   rot_sum;
    logic [RBITS-1:0] rot_p;
    assign rot_sum = {1'b0, phase_i} + HALF_W;
    assign rot_p   = (rot_sum >= RATIO_W) ? RBITS'(rot_sum - RATIO_W) : rot_sum[RBITS-1:0];

    // Both candidate centres; the narrower spread wins, ties go straight.
    logic [RBITS-1:0] ss, sr, mid_s, mid_r;
    logic [RBITS:0]   sum_s, sum_r, back_sum;
    assign ss       = max_q - min_q;
    assign sr       = maxr_q - minr_q;
    assign sum_s    = {1'b0, min_q} + {1'b0, max_q};
    assign sum_r    = {1'b0, minr_q} + {1'b0, maxr_q};
    assign mid_s    = sum_s[RBITS:1];
    assign back_sum = {1'b0, sum_r[RBITS:1]} + BACK_W;
    assign mid_r    = (back_sum >= RATIO_W) ? RBITS'(back_sum - RATIO_W) : back_sum[RBITS-1:0];

    logic accept, chan_fail;
    assign accept    = strobe_i && locked_i && (settle_q == SETTLE_M1);
    assign chan_fail = invalid_i || (tmo_q == TMO_LAST);

    // Next-state, datapath updates and decoded outputs (registered below).
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        flush_cnt_d = flush_cnt_q;
        settle_d    = settle_q;
        tmo_d       = tmo_q;
        min_d       = min_q;
        max_d       = max_q;
        minr_d      = minr_q;
        maxr_d      = maxr_q;
        any_d       = any_q;
        fail_work_d = fail_work_q;
        phase_d     = phase_q;
        spread_d    = spread_q;
        valid_d     = valid_q;
        fail_d      = fail_q;

        busy_d    = (state_q == S_FLUSH) || (state_q == S_ALIGN) || (state_q == S_NEXT);
        done_d    = (state_q == S_FINISH);
        align_d   = (state_q == S_ALIGN);
        cstart_d  = (state_q == S_ALIGN) && (tmo_q == '0);
        creset_d  = (state_q == S_FLUSH) && (flush_cnt_q == '0);
        restart_d = (state_q == S_FLUSH) && (flush_cnt_q == '0);

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sel_d       = '0;
                    flush_cnt_d = '0;
                    min_d       = '1;
                    max_d       = '0;
                    minr_d      = '1;
                    maxr_d      = '0;
                    any_d       = 1'b0;
                    state_d     = S_FLUSH;
                end
            end
            S_FLUSH: begin
                flush_cnt_d = flush_cnt_q + FCW'(1);
                if (flush_cnt_q == FLUSH_END) begin
                    tmo_d    = '0;
                    settle_d = '0;
                    state_d  = S_ALIGN;
                end
            end
            S_ALIGN: begin
                tmo_d = tmo_q + TBITS'(1);
                if (!locked_i) begin
                    settle_d = '0;
                end else if (strobe_i) begin
                    settle_d = settle_q + STW'(1);
                end
                if (chan_fail) begin
                    fail_work_d[sel_q] = 1'b1;
                    state_d            = S_NEXT;
                end else if (accept) begin
                    fail_work_d[sel_q] = 1'b0;
                    any_d              = 1'b1;
                    if (phase_i < min_q) min_d = phase_i;
                    if (phase_i > max_q) max_d = phase_i;
                    if (rot_p < minr_q) minr_d = rot_p;
                    if (rot_p > maxr_q) maxr_d = rot_p;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (sel_q == SEL_LAST) begin
                    state_d = S_FINISH;
                end else begin
                    sel_d       = sel_q + SBITS'(1);
                    flush_cnt_d = '0;
                    state_d     = S_FLUSH;
                end
            end
            S_FINISH: begin
                fail_d  = fail_work_q;
                valid_d = any_q;
                if (!any_q) begin
                    phase_d  = '0;
                    spread_d = '0;
                end else if (ss <= sr) begin
                    phase_d  = mid_s;
                    spread_d = ss;
                end else begin
                    phase_d  = mid_r;
                    spread_d = sr;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and output registers; reset abandons any sweep at once.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            flush_cnt_q <= '0;
            settle_q    <= '0;
            tmo_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            minr_q      <= '0;
            maxr_q      <= '0;
            any_q       <= 1'b0;
            fail_work_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            align_q     <= 1'b0;
            cstart_q    <= 1'b0;
            creset_q    <= 1'b0;
            restart_q   <= 1'b0;
            phase_q     <= '0;
            spread_q    <= '0;
            valid_q     <= 1'b0;
            fail_q      <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            flush_cnt_q <= flush_cnt_d;
            settle_q    <= settle_d;
            tmo_q       <= tmo_d;
            min_q       <= min_d;
            max_q       <= max_d;
            minr_q      <= minr_d;
            maxr_q      <= maxr_d;
            any_q       <= any_d;
            fail_work_q <= fail_work_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            align_q     <= align_d;
            cstart_q    <= cstart_d;
            creset_q    <= creset_d;
            restart_q   <= restart_d;
            phase_q     <= phase_d;
            spread_q    <= spread_d;
            valid_q     <= valid_d;
            fail_q      <= fail_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign select_o  = sel_q;
    assign align_o   = align_q;
    assign cstart_o  = cstart_q;
    assign creset_o  = creset_q;
    assign restart_o = restart_q;
    assign phase_o   = phase_q;
    assign spread_o  = spread_q;
    assign valid_o   = valid_q;
    assign fail_o    = fail_q;

endmodule

// File: tb/tb_capture_sweep.sv
// Directed bench for capture_sweep with a small behavioural signal_centre.
module tb_capture_sweep;

    logic        clock_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, align_o, cstart_o, creset_o, restart_o;
    logic [4:0]  select_o;
    logic        strobe_i = 1'b0, locked_i = 1'b0, invalid_i = 1'b0;
    logic [3:0]  phase_i = '0;
    logic [3:0]  phase_o, spread_o;
    logic        valid_o;
    logic [23:0] fail_o;

    always #5 clock_i = ~clock_i;

    capture_sweep dut (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .start_i  (start_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .select_o (select_o),
        .align_o  (align_o),
        .cstart_o (cstart_o),
        .creset_o (creset_o),
        .restart_o(restart_o),
        .strobe_i (strobe_i),
        .locked_i (locked_i),
        .invalid_i(invalid_i),
        .phase_i  (phase_i),
        .phase_o  (phase_o),
        .spread_o (spread_o),
        .valid_o  (valid_o),
        .fail_o   (fail_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Per-channel behaviour: 0 = locks at ph[n], 1 = raises invalid, 2 = never locks.
    int         mode [32];
    logic [3:0] ph   [32];
    int         a_cnt    = 0;
    logic       inv      = 1'b0;
    int         rs_sel   = -1;
    int         done_cnt = 0;
    int         a10_cnt  = 0;

    logic [23:0] exp_fail_held  = '0;
    logic        exp_valid_held = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // signal_centre stand-in: strobes every third aligned cycle, locked while aligned.
    initial begin
        forever begin
            @(negedge clock_i);
            if (!reset_ni) begin
                a_cnt = 0;
                inv   = 1'b0;
            end else begin
                if (align_o) a_cnt++;
                else a_cnt = 0;
                if (restart_o && inv) rs_sel = int'(select_o);
                if (restart_o) inv = 1'b0;
                if (align_o && mode[select_o] == 1 && a_cnt >= 4) inv = 1'b1;
                if (done_o) done_cnt++;
                if (align_o && select_o == 5'd10) a10_cnt++;
            end
            strobe_i  = align_o && (a_cnt > 0) && (a_cnt % 3 == 0);
            locked_i  = align_o && (mode[select_o] == 0);
            phase_i   = ph[select_o];
            invalid_i = inv;
        end
    end

    task automatic start_sweep(input string name);
        @(negedge clock_i);
        start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        check({name, "_busy_k"}, 64'(busy_o), 64'd0);
        @(negedge clock_i);
        check({name, "_busy_k1"}, 64'(busy_o), 64'd1);
        check({name, "_creset_k1"}, 64'(creset_o), 64'd1);
        check({name, "_restart_k1"}, 64'(restart_o), 64'd1);
        check({name, "_select0"}, 64'(select_o), 64'd0);
        check({name, "_fail_held"}, 64'(fail_o), 64'(exp_fail_held));
        check({name, "_valid_held"}, 64'(valid_o), 64'(exp_valid_held));
        @(negedge clock_i);
        check({name, "_creset_k2"}, 64'(creset_o), 64'd0);
    endtask

    task automatic finish_sweep(input string name, input int budget, input logic [3:0] e_phase,
                                input logic [3:0] e_spread, input logic e_valid,
                                input logic [23:0] e_fail, input int done_before);
        int cyc;
        cyc = 0;
        while (!done_o && cyc < budget) begin
            @(negedge clock_i);
            cyc++;
        end
        check({name, "_done_seen"}, 64'(done_o), 64'd1);
        check({name, "_busy_at_done"}, 64'(busy_o), 64'd0);
        check({name, "_phase"}, 64'(phase_o), 64'(e_phase));
        check({name, "_spread"}, 64'(spread_o), 64'(e_spread));
        check({name, "_valid"}, 64'(valid_o), 64'(e_valid));
        check({name, "_fail"}, 64'(fail_o), 64'(e_fail));
        $display("sweep %s: phase=%0d spread=%0d valid=%0d fail=%06h after %0d cycles",
                 name, phase_o, spread_o, valid_o, fail_o, cyc);
        @(negedge clock_i);
        @(negedge clock_i);
        check({name, "_done_pulse"}, 64'(done_o), 64'd0);
        check({name, "_done_count"}, 64'(done_cnt - done_before), 64'd1);
        exp_fail_held  = e_fail;
        exp_valid_held = e_valid;
    endtask

    initial begin
        int db;
        int cyc;
        for (int n = 0; n < 32; n++) begin
            mode[n] = 0;
            ph[n]   = 4'd5;
        end

        // Reset state
        repeat (3) @(negedge clock_i);
        check("rst_outputs", {busy_o, done_o, select_o, align_o, cstart_o, creset_o, restart_o,
                              phase_o, spread_o, valid_o, fail_o}, 64'd0);
        reset_ni = 1'b1;
        repeat (2) @(negedge clock_i);

        // 1: all channels at phase 5
        db = done_cnt;
        start_sweep("s1");
        finish_sweep("s1", 1000, 4'd5, 4'd0, 1'b1, 24'h0, db);

        // 2: phases 2..6, with a start poke mid-sweep that must be ignored
        for (int n = 0; n < 24; n++) ph[n] = 4'(2 + (n % 5));
        db = done_cnt;
        start_sweep("s2");
        repeat (40) @(negedge clock_i);
        start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        finish_sweep("s2", 1000, 4'd4, 4'd4, 1'b1, 24'h0, db);

        // 3: phases wrap around zero -> rotated form
        for (int n = 0; n < 24; n++) ph[n] = (n % 3 == 0) ? 4'd11 : ((n % 3 == 1) ? 4'd0 : 4'd1);
        db = done_cnt;
        start_sweep("s3");
        finish_sweep("s3", 1000, 4'd0, 4'd2, 1'b1, 24'h0, db);

        // 4: channel 3 invalid, others phase 7
        for (int n = 0; n < 24; n++) ph[n] = 4'd7;
        mode[3] = 1;
        rs_sel  = -1;
        db = done_cnt;
        start_sweep("s4");
        finish_sweep("s4", 1000, 4'd7, 4'd0, 1'b1, 24'h000008, db);
        check("s4_restart_sel", 64'(rs_sel), 64'd4);
        mode[3] = 0;

        // 5: channel 10 times out, others phase 3
        for (int n = 0; n < 24; n++) ph[n] = 4'd3;
        mode[10] = 2;
        a10_cnt  = 0;
        db = done_cnt;
        start_sweep("s5");
        finish_sweep("s5", 6000, 4'd3, 4'd0, 1'b1, 24'h000400, db);
        check("s5_timeout_cycles", 64'(a10_cnt), 64'd4095);
        mode[10] = 0;

        // 5b: no channel locks at all
        for (int n = 0; n < 24; n++) mode[n] = 1;
        db = done_cnt;
        start_sweep("s6");
        finish_sweep("s6", 1000, 4'd0, 4'd0, 1'b0, 24'hFFFFFF, db);

        // 6: reset during channel 12's ALIGN, then a fresh sweep
        for (int n = 0; n < 24; n++) begin
            mode[n] = 0;
            ph[n]   = 4'd6;
        end
        mode[12] = 2;
        db = done_cnt;
        start_sweep("s7");
        cyc = 0;
        while (!(align_o && select_o == 5'd12) && cyc < 1000) begin
            @(negedge clock_i);
            cyc++;
        end
        check("s7_reached_ch12", 64'(align_o && select_o == 5'd12), 64'd1);
        repeat (5) @(negedge clock_i);
        #2 reset_ni = 1'b0;
        #1;
        check("s7_async_reset", {busy_o, done_o, select_o, align_o, cstart_o, creset_o, restart_o,
                                 phase_o, spread_o, valid_o, fail_o}, 64'd0);
        repeat (3) @(negedge clock_i);
        reset_ni = 1'b1;
        repeat (10) @(negedge clock_i);
        check("s7_no_done", 64'(done_cnt - db), 64'd0);
        check("s7_idle_busy", 64'(busy_o), 64'd0);
        exp_fail_held  = '0;
        exp_valid_held = 1'b0;
        for (int n = 0; n < 24; n++) ph[n] = 4'd9;
        mode[12] = 0;
        db = done_cnt;
        start_sweep("s8");
        finish_sweep("s8", 1000, 4'd9, 4'd0, 1'b1, 24'h0, db);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
